// File: rtl/md_if.sv
// md_if: request/result bundle between the EX-stage control and md_unit.
//   master (EX control): drives start/op/a/b/cancel/hi_we/lo_we/wdata,
//                        observes busy/hi/lo
//   slave  (md_unit)   : the reverse
interface md_if;
  logic        start;
  logic [1:0]  op;      // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_we, lo_we, wdata,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_we, lo_we, wdata,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: iterative 32-bit multiply/divide unit owning the HI/LO registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : md_if.slave -- start/op/a/b request, cancel (flush),
//                MTHI/MTLO writes (hi_we/lo_we/wdata), busy/hi/lo results
// An accepted operation spends 32 cycles in CALC (one bit per cycle) and one
// in FIX (sign correction and HI/LO write), so busy is high for 33 cycles.
module md_unit (
  input  logic clk,
  input  logic rst_n,
  md_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic        is_div;
  logic [31:0] mag_b;
  logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic        neg_q;     // negate product (mul) or quotient (div)
  logic        neg_r;     // negate remainder (div only)
  logic        div_zero;
  logic [31:0] hi_q, lo_q;

  // Operand capture: magnitudes only for signed ops.
  logic        signed_op, a_neg, b_neg, start_go;
  logic [31:0] mag_a_in, mag_b_in;

  assign signed_op = ~bus.op[0];
  assign a_neg     = signed_op & bus.a[31];
  assign b_neg     = signed_op & bus.b[31];
  assign mag_a_in  = a_neg ? -bus.a : bus.a;
  assign mag_b_in  = b_neg ? -bus.b : bus.b;
  // Cancel beats start in IDLE.
  assign start_go  = bus.start & ~bus.cancel;

  // One iteration of shift-add multiply or restoring divide.
  logic [32:0] add_sum;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_next;
  logic [63:0] acc_step;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_step  = acc;
    add_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    rem_shift = {acc[63:32], acc[31]};
    rem_ge    = (rem_shift >= {1'b0, mag_b});
    // After a restore the remainder is below the divisor, so 32 bits suffice.
    rem_next  = rem_ge ? (rem_shift[31:0] - mag_b) : rem_shift[31:0];
    if (is_div)
      acc_step = {rem_next, acc[30:0], rem_ge};
    else
      acc_step = {add_sum, acc[31:1]};
  end

  // Sign correction applied in FIX.
  logic [63:0] prod_fixed;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    prod_fixed = neg_q ? -acc : acc;
    fix_hi     = prod_fixed[63:32];
    fix_lo     = prod_fixed[31:0];
    if (is_div) begin
      // A zero divisor yields an all-ones quotient; the remainder already
      // reconstructs the original dividend once its sign is restored.
      fix_hi = neg_r ? -acc[63:32] : acc[63:32];
      if (div_zero)
        fix_lo = 32'hFFFF_FFFF;
      else
        fix_lo = neg_q ? -acc[31:0] : acc[31:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_go) state_next = CALC;
      CALC: begin
        if (bus.cancel)         state_next = IDLE;
        else if (count == 5'd31) state_next = FIX;
      end
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      is_div   <= 1'b0;
      mag_b    <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_go) begin
            count    <= '0;
            is_div   <= bus.op[1];
            mag_b    <= mag_b_in;
            acc      <= {32'd0, mag_a_in};
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (bus.b == 32'd0);
          end else begin
            // MTHI/MTLO only land when no operation is being accepted.
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            acc   <= acc_step;
            count <= count + 5'd1;
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_md_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  md_if bus ();

  md_unit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one operation, count busy cycles, then check HI/LO.
  // poke > 0: on that busy cycle, pulse a DIVU start plus an MTHI of 0xDEAD,
  // both of which must be ignored.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int poke);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (poke > 0 && n == poke) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd99; bus.b = 32'd4;
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_DEAD;
      end else begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check({tag, " busy cycles"}, 32'(n), 32'd33);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    #12;
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    rst_n = 1'b1;

    run_op("mult -1*2",     OP_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("multu ffff*2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_op("div -7/2",      OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("divu 100/7",    OP_DIVU,  32'd100,       32'd7, 32'd2,         32'd14,        0);
    run_op("divu by zero",  OP_DIVU,  32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0);
    run_op("div neg by 0",  OP_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
    run_op("div overflow",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
    run_op("multu ignored", OP_MULTU, 32'd3,         32'd5, 32'd0,         32'd15,        10);
    @(negedge clk);
    check("no queued start", {31'd0, bus.busy}, 32'd0);

    // MTHI then MTLO in IDLE.
    bus.hi_we = 1'b1; bus.wdata = 32'hAAAA_0000;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h0000_5555;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mthi", bus.hi, 32'hAAAA_0000);
    check("mtlo", bus.lo, 32'h0000_5555);

    // Cancel a DIV at busy cycle 20.
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    check("busy before cancel", {31'd0, bus.busy}, 32'd1);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel busy", {31'd0, bus.busy}, 32'd0);
    check("cancel hi", bus.hi, 32'hAAAA_0000);
    check("cancel lo", bus.lo, 32'h0000_5555);

    // Cancel together with start in IDLE: nothing starts.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULTU;
    @(negedge clk);
    bus.start = 1'b0; bus.cancel = 1'b0;
    check("cancel+start busy", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset in the middle of a MULT.
    bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd5; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset hi", bus.hi, 32'd0);
    check("midreset lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("multu 6*7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
